rtc_write_seq: RTL and testbench

Write sequencer for the RTC programming path, the counterpart of the read-sequencer that polls the clock, date and timer registers. On a start request it performs a fixed ordered series of twelve write transactions through the low-level RTC bus driver. The series is: lock updates, nine data registers (seconds, minutes, hours, day, month, year, timer s/m/h), release, then the timer-transfer command. Data bytes are fetched from the local register bank using the same `dir_reg` index (1..9) the read path uses, so values read back can be edited and written back.

---
 rtl/rtc_write_seq.sv | 170 +++++++++++++++++
 tb/tb_rtc_write_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_write_seq.sv
// RTC write sequencer: issues the fixed twelve-transaction programming
// series (lock, nine data registers, release, transfer) to the bus driver.
module rtc_write_seq #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       fin_i,
    input  logic [7:0] dato_in_i,
    output logic [7:0] dirout_o,
    output logic [3:0] dir_reg_o,
    output logic [7:0] dato_o,
    output logic       escritura_o,
    output logic       ocupado_o,
    output logic       final_o,
    output logic       error_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [3:0] LAST_IDX = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT_FIN,
        DONE,
        ERROR
    } state_t;

    state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] dirout_q, dirout_d;
    logic [3:0] dir_reg_q, dir_reg_d;
    logic [7:0] dato_q, dato_d;
    logic esc_q, esc_d;
    logic ocu_q, ocu_d;
    logic final_q, final_d;
    logic err_q, err_d;

    function automatic logic [7:0] tab_addr(input logic [3:0] i);
        logic [7:0] a;
        a = 8'h00;
        if (i >= 4'd1 && i <= 4'd6) a = 8'h20 + {4'h0, i};
        else if (i >= 4'd7 && i <= 4'd9) a = 8'h2A + {4'h0, i};
        else if (i == 4'd11) a = 8'hF2;
        return a;
    endfunction

    function automatic logic [3:0] tab_reg(input logic [3:0] i);
        return (i >= 4'd1 && i <= 4'd9) ? i : 4'd0;
    endfunction

    // Only the lock transaction carries a non-zero constant.
    function automatic logic [7:0] tab_const(input logic [3:0] i);
        return (i == 4'd0) ? 8'h10 : 8'h00;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dirout_d  = dirout_q;
        dir_reg_d = dir_reg_q;
        dato_d    = dato_q;
        esc_d     = 1'b0;
        ocu_d     = 1'b0;
        final_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                dirout_d  = 8'h00;
                dir_reg_d = 4'd0;
                dato_d    = 8'h00;
                if (iniciar_i) begin
                    state_d   = SETUP;
                    idx_d     = 4'd0;
                    cnt_d     = '0;
                    dirout_d  = tab_addr(4'd0);
                    dir_reg_d = tab_reg(4'd0);
                    ocu_d     = 1'b1;
                end
            end
            SETUP: begin
                state_d = WAIT_FIN;
                cnt_d   = '0;
                esc_d   = 1'b1;
                ocu_d   = 1'b1;
                dato_d  = (tab_reg(idx_q) != 4'd0) ? dato_in_i
                                                   : tab_const(idx_q);
            end
            WAIT_FIN: begin
                if (fin_i) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d   = DONE;
                        idx_d     = 4'd0;
                        dirout_d  = 8'h00;
                        dir_reg_d = 4'd0;
                        dato_d    = 8'h00;
                        final_d   = 1'b1;
                    end else begin
                        state_d   = SETUP;
                        idx_d     = idx_q + 4'd1;
                        dirout_d  = tab_addr(idx_q + 4'd1);
                        dir_reg_d = tab_reg(idx_q + 4'd1);
                        ocu_d     = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d   = ERROR;
                    idx_d     = 4'd0;
                    cnt_d     = '0;
                    dirout_d  = 8'h00;
                    dir_reg_d = 4'd0;
                    dato_d    = 8'h00;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    esc_d = 1'b1;
                    ocu_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                idx_d     = 4'd0;
                cnt_d     = '0;
                dirout_d  = 8'h00;
                dir_reg_d = 4'd0;
                dato_d    = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            dirout_q  <= 8'h00;
            dir_reg_q <= 4'd0;
            dato_q    <= 8'h00;
            esc_q     <= 1'b0;
            ocu_q     <= 1'b0;
            final_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dirout_q  <= dirout_d;
            dir_reg_q <= dir_reg_d;
            dato_q    <= dato_d;
            esc_q     <= esc_d;
            ocu_q     <= ocu_d;
            final_q   <= final_d;
            err_q     <= err_d;
        end
    end

    assign dirout_o    = dirout_q;
    assign dir_reg_o   = dir_reg_q;
    assign dato_o      = dato_q;
    assign escritura_o = esc_q;
    assign ocupado_o   = ocu_q;
    assign final_o     = final_q;
    assign error_o     = err_q;

endmodule

// File: tb/tb_rtc_write_seq.sv
// Directed bench for rtc_write_seq: full sequence, minimum latency,
// timeout, asynchronous reset and spurious-input runs.
module tb_rtc_write_seq;

    logic clk = 1'b0;
    logic reset, iniciar, fin;
    logic [7:0] dato_in, dirout, dato;
    logic [3:0] dir_reg;
    logic escritura, ocupado, final_s, error_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] ea [12] = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                            8'h26, 8'h31, 8'h32, 8'h33, 8'h00, 8'hF2};
    logic [3:0] er [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                            4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0};
    logic [7:0] ed [12] = '{8'h10, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45,
                            8'h46, 8'h47, 8'h48, 8'h49, 8'h00, 8'h00};

    // Register bank model: byte = 0x40 + index.
    assign dato_in = 8'h40 + {4'h0, dir_reg};

    rtc_write_seq #(.TIMEOUT(8)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .iniciar_i  (iniciar),
        .fin_i      (fin),
        .dato_in_i  (dato_in),
        .dirout_o   (dirout),
        .dir_reg_o  (dir_reg),
        .dato_o     (dato),
        .escritura_o(escritura),
        .ocupado_o  (ocupado),
        .final_o    (final_s),
        .error_o    (error_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dirout"}, dirout, 0);
        chk({tag, "_dirreg"}, dir_reg, 0);
        chk({tag, "_dato"}, dato, 0);
        chk({tag, "_esc"}, escritura, 0);
        chk({tag, "_ocu"}, ocupado, 0);
    endtask

    // Entered in SETUP; fin is sampled at the dly-th edge after escritura rises.
    task automatic txn(input int i, input int dly, input bit spur);
        int n;
        chk($sformatf("setup_addr%0d", i), dirout, ea[i]);
        chk($sformatf("setup_reg%0d", i), dir_reg, er[i]);
        chk($sformatf("setup_esc%0d", i), escritura, 0);
        chk($sformatf("setup_ocu%0d", i), ocupado, 1);
        n = 0;
        while (escritura !== 1'b1 && n < 16) begin
            if (spur && n == 0) fin = 1'b1;
            tick;
            fin = 1'b0;
            n++;
        end
        chk($sformatf("esc_delay%0d", i), n, 1);
        chk($sformatf("addr%0d", i), dirout, ea[i]);
        chk($sformatf("reg%0d", i), dir_reg, er[i]);
        chk($sformatf("dato%0d", i), dato, ed[i]);
        chk($sformatf("noerr%0d", i), error_s, 0);
        for (int c = 1; c < dly; c++) begin
            if (spur) iniciar = 1'b1;
            tick;
            iniciar = 1'b0;
            chk($sformatf("hold_esc%0d", i), escritura, 1);
            chk($sformatf("hold_addr%0d", i), dirout, ea[i]);
            chk($sformatf("hold_dato%0d", i), dato, ed[i]);
        end
        fin = 1'b1;
        tick;
        fin = 1'b0;
        chk($sformatf("esc_drop%0d", i), escritura, 0);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_final"}, final_s, 1);
        chk({tag, "_err"}, error_s, 0);
        chk_zero(tag);
        tick;
        chk({tag, "_final_off"}, final_s, 0);
        chk({tag, "_idle_ocu"}, ocupado, 0);
    endtask

    task automatic full_seq(input int dly, input bit spur);
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        for (int i = 0; i < 12; i++) txn(i, dly, spur);
        check_done(spur ? "spur_done" : "full_done");
    endtask

    initial begin
        int n, rises;
        bit prev, long_esc;
        reset = 1'b1;
        iniciar = 1'b0;
        fin = 1'b0;
        #3;
        chk_zero("reset");
        chk("reset_final", final_s, 0);
        chk("reset_err", error_s, 0);
        #10;
        reset = 1'b0;
        tick;
        chk("idle_ocu", ocupado, 0);

        full_seq(3, 1'b0);

        // Minimum latency: fin tied high.
        fin = 1'b1;
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        n = 0;
        rises = 0;
        prev = 1'b0;
        long_esc = 1'b0;
        while (final_s !== 1'b1 && n < 40) begin
            tick;
            n++;
            if (escritura && prev) long_esc = 1'b1;
            if (escritura && !prev) rises++;
            prev = escritura;
        end
        fin = 1'b0;
        chk("minlat_edges", n, 24);
        chk("minlat_rises", rises, 12);
        chk("minlat_onecyc", long_esc, 0);
        chk("minlat_err", error_s, 0);
        tick;
        chk("minlat_final_off", final_s, 0);

        // Timeout at index 4.
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        for (int i = 0; i < 4; i++) txn(i, 1, 1'b0);
        chk("to_setup_addr", dirout, 8'h24);
        tick;
        chk("to_esc_rise", escritura, 1);
        for (int c = 1; c < 8; c++) begin
            tick;
            chk("to_wait_esc", escritura, 1);
            chk("to_wait_err", error_s, 0);
        end
        tick;
        chk("to_err", error_s, 1);
        chk("to_final", final_s, 0);
        chk_zero("to");
        tick;
        chk("to_err_off", error_s, 0);
        chk("to_idle_ocu", ocupado, 0);
        chk("to_idle_final", final_s, 0);

        // fin on the last permitted cycle wins.
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        for (int i = 0; i < 12; i++) txn(i, (i == 4) ? 8 : 1, 1'b0);
        check_done("to8_done");

        // Asynchronous reset during index 7.
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        for (int i = 0; i < 7; i++) txn(i, 1, 1'b0);
        tick;
        chk("rst_pre_esc", escritura, 1);
        chk("rst_pre_addr", dirout, 8'h31);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("rst_async");
        iniciar = 1'b1;
        #2;
        reset = 1'b0;
        tick;
        chk("rst_restart_ocu", ocupado, 1);
        iniciar = 1'b0;
        for (int i = 0; i < 12; i++) txn(i, 1, 1'b0);
        check_done("rst_done");

        // Spurious fin in IDLE, then spurious fin/iniciar inside the run.
        fin = 1'b1;
        tick;
        tick;
        fin = 1'b0;
        chk("spur_idle_ocu", ocupado, 0);
        chk("spur_idle_esc", escritura, 0);
        full_seq(3, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
